cpu_run_ctrl: RTL
=================

Name: cpu_run_ctrl

Overview:
- Synthesizable run controller that gates the 24-bit CPU's clock enable.
- Supported run modes:
  - a programmable cycle budget,
  - free-run until halt,
  - single-step.
- Reports cycle count and stop reason.
- Sits between the top level or debug logic and the CPU core. It replaces fixed-length clocking ("run N edges then stop") with a parametrised, controllable block usable in both silicon and benches.

Parameters:
- CNT_W, 24, width of Budget and CycleCount.
- DEFAULT_BUDGET, 30, budget used when Start is pulsed with UseDefault=1.

Ports:
- Clock  in  1  system clock, rising-edge.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  one-cycle pulse: begin a budgeted or free run.
- UseDefault  in  1  sampled with Start: 1 = load DEFAULT_BUDGET, 0 = load Budget.
- Budget  in  CNT_W  cycle budget sampled on Start; 0 = free-run.
- Step  in  1  one-cycle pulse: enable the CPU for exactly one cycle.
- Halt  in  1  external abort request, level or pulse.
- CpuHaltReq  in  1  CPU executed a halt instruction; sampled only while CpuEn=1.
- CpuEn  out  1  registered clock enable to the CPU.
- Running  out  1  high in RUN state.
- Done  out  1  high in DONE state (level).
- Reason  out  2  stop reason, valid while Done=1: 0 budget, 1 ext halt, 2 cpu halt, 3 breakpoint.
- CycleCount  out  CNT_W  count of cycles with CpuEn=1.

Behaviour:
- Reset (asynchronous, active-high):
  - State=IDLE.
  - CpuEn, Running, Done, Reason and CycleCount all 0.
  - Reset asserted mid-run drops CpuEn immediately, without waiting for a clock edge.
- States: IDLE, RUN, STEP, DONE.
- IDLE/DONE, Start=1:
  - Latch the budget into an internal register.
  - Clear CycleCount.
  - Next state RUN.
  - CpuEn=1 from the following cycle.
  - Done clears.
- IDLE/DONE, Step=1 with Start=0:
  - Next state STEP; CpuEn=1 for exactly one cycle.
  - Then return to the state STEP was entered from.
  - CycleCount is not cleared on Step, so repeated steps accumulate.
  - Start and Step in the same cycle: Start wins.
- Start or Step while in RUN or STEP: ignored.
- CycleCount:
  - Increments on every edge at which CpuEn=1.
  - Saturates at all-ones; no wrap.
- RUN exit conditions, evaluated each cycle, priority Halt > CpuHaltReq > breakpoint > budget:
  - Halt=1 → DONE, Reason=1.
  - CpuHaltReq=1 → DONE, Reason=2.
  - Latched budget B≠0 and CycleCount+1==B → DONE, Reason=0.
- Exit timing:
  - The cycle in which the exit is detected still has CpuEn=1 and is counted.
  - CpuEn=0 from the next cycle.
  - Result: a budget of B gives exactly B CpuEn cycles and final CycleCount=B.
  - B=1 gives a single enabled cycle.
- Free-run (B=0): runs until Halt or CpuHaltReq. The counter saturates but the run continues.
- Halt seen in IDLE or DONE: no effect.
- Halt during STEP: the step completes; no effect.
- CpuHaltReq during STEP: the step completes, then DONE with Reason=2.
- Running = (state==RUN). Done = (state==DONE). Both are registered and change on the same edge as CpuEn.

Optional Feature:
- Macro: CPU_RUN_BREAKPOINT_EN.
- When defined:
  - Adds ports Pc (in, CNT_W, CPU program counter) and BreakAddr (in, CNT_W).
  - Adds BreakEn (in, 1).
  - In RUN with CpuEn=1 and BreakEn=1, Pc==BreakAddr → DONE, Reason=3, with the same exit timing as the other conditions.
  - Checked neither in STEP nor in the first RUN cycle after Start, so a run can resume from a breakpoint.
- When undefined: these ports do not exist and Reason never equals 3.

Test Plan:
- Reset, then Start with UseDefault=1 → CpuEn high exactly 30 consecutive cycles; Done=1, Reason=0, CycleCount=30.
- Start, Budget=5; after 5 cycles Step ×3 → CycleCount 5, then 6, 7, 8; each step gives a 1-cycle CpuEn pulse; state returns to DONE.
- Start, Budget=0; assert Halt on the 100th enabled cycle → CycleCount=100, Reason=1; CpuEn low the next cycle.
- Start, Budget=50; CpuHaltReq on enabled cycle 10 together with Halt → Reason=1 (priority); repeat with CpuHaltReq alone → Reason=2, CycleCount=10.
- Start, Budget=20; assert Reset at cycle 7 → CpuEn and all outputs 0 asynchronously; after release, Start with Budget=3 → exactly 3 CpuEn cycles.
- With CPU_RUN_BREAKPOINT_EN: BreakAddr=0x000010, Pc incrementing from 0 → Done with Reason=3 on the cycle Pc=0x10; a subsequent Start resumes without re-triggering on the first cycle.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run controller that gates the CPU clock enable.
// Run modes: budgeted run (budget != 0), free-run until halt (budget == 0)
// and single-step. Reports the number of enabled cycles and why it stopped.
// Optional breakpoint compare is built when CPU_RUN_BREAKPOINT_EN is defined.
// Control inputs start/step are single-cycle pulses with no back-pressure:
// they are acted on only in IDLE/DONE and silently dropped in RUN/STEP.
module cpu_run_ctrl #(
  parameter int CNT_W          = 24,
  parameter int DEFAULT_BUDGET = 30
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             use_default,
  input  logic [CNT_W-1:0] budget,
  input  logic             step,
  input  logic             halt,
  input  logic             cpu_halt_req,
`ifdef CPU_RUN_BREAKPOINT_EN
  input  logic [CNT_W-1:0] pc,
  input  logic [CNT_W-1:0] break_addr,
  input  logic             break_en,
`endif
  output logic             cpu_en,
  output logic             running,
  output logic             done,
  output logic [1:0]       reason,
  output logic [CNT_W-1:0] cycle_count,
  output logic [1:0]       state_dbg
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] STEP = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [1:0] R_BUDGET = 2'd0;
  localparam logic [1:0] R_EXT    = 2'd1;
  localparam logic [1:0] R_CPU    = 2'd2;
  localparam logic [1:0] R_BREAK  = 2'd3;

  logic [1:0]       state;
  logic [1:0]       next_state;
  logic [1:0]       ret_state;
  logic [1:0]       next_reason;
  logic [CNT_W-1:0] budget_q;
  logic             first_q;
  logic             load;
  logic             bp_hit;
  logic [CNT_W:0]   cnt_inc;
  logic             budget_hit;

  assign state_dbg = state;

  // Count including the current enabled cycle; one bit wider so the
  // compare never aliases when the counter sits at all-ones.
  assign cnt_inc    = {1'b0, cycle_count} + {{CNT_W{1'b0}}, 1'b1};
  assign budget_hit = (budget_q != '0) && (cnt_inc == {1'b0, budget_q});

`ifdef CPU_RUN_BREAKPOINT_EN
  // The first RUN cycle after start is exempt so a run can resume from a breakpoint.
  assign bp_hit = break_en && !first_q && (pc == break_addr);
`else
  assign bp_hit = 1'b0;
`endif

  // Next-state and stop-reason selection; exits ranked halt > cpu halt > breakpoint > budget.
  always_comb begin
    next_state  = state;
    next_reason = reason;
    load        = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          next_state = RUN;
          load       = 1'b1;
        end else if (step) begin
          next_state = STEP;
        end
      end
      RUN: begin
        if (halt) begin
          next_state  = DONE;
          next_reason = R_EXT;
        end else if (cpu_halt_req) begin
          next_state  = DONE;
          next_reason = R_CPU;
        end else if (bp_hit) begin
          next_state  = DONE;
          next_reason = R_BREAK;
        end else if (budget_hit) begin
          next_state  = DONE;
          next_reason = R_BUDGET;
        end
      end
      STEP: begin
        if (cpu_halt_req) begin
          next_state  = DONE;
          next_reason = R_CPU;
        end else begin
          next_state = ret_state;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State, registered status outputs and the return point for a single step.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ret_state <= IDLE;
      cpu_en    <= 1'b0;
      running   <= 1'b0;
      done      <= 1'b0;
      reason    <= R_BUDGET;
      first_q   <= 1'b0;
    end else begin
      state   <= next_state;
      cpu_en  <= (next_state == RUN) || (next_state == STEP);
      running <= (next_state == RUN);
      done    <= (next_state == DONE);
      reason  <= next_reason;
      first_q <= load;
      if (((state == IDLE) || (state == DONE)) && (next_state == STEP))
        ret_state <= state;
    end
  end

  // Budget latch on start; use_default selects the built-in budget.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      budget_q <= '0;
    else if (load)
      budget_q <= use_default ? CNT_W'(DEFAULT_BUDGET) : budget;
  end

  // Enabled-cycle counter: cleared on start, saturating at all-ones.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      cycle_count <= '0;
    else if (load)
      cycle_count <= '0;
    else if (cpu_en && (cycle_count != {CNT_W{1'b1}}))
      cycle_count <= cnt_inc[CNT_W-1:0];
  end

endmodule
